bram_read_streamer: RTL and testbench
=====================================

Name: bram_read_streamer

Overview:
- Read-side master for the simple-dual-port buffer RAM: drives the read enable and read address, and captures the read data.
- Streams a contiguous run of buffer entries out on a valid/ready interface.
- Feeds the compute datapath (systolic array / output path) from the unified buffer.
- A 2-entry output FIFO with credit counting absorbs back-pressure, given the RAM's 1-cycle read latency.

Parameters:
- RAM_WIDTH, 128, entry width in bits; must match the buffer RAM.
- RAM_DEPTH, 256, number of buffer entries.
- ADDR_W, clogb2(RAM_DEPTH-1) = 8, RAM address width.
- LEN_W, ADDR_W+1 = 9, transfer-length width (0..RAM_DEPTH entries).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_W  first entry to read; latched on accepted start.
- length  in  LEN_W  number of entries; latched on accepted start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- bram_enb  out  1  RAM read enable; registered.
- bram_addrb  out  ADDR_W  RAM read address; registered.
- bram_doutb  in  RAM_WIDTH  RAM read data; valid at the rising edge following the cycle in which bram_enb was high.
- m_data  out  RAM_WIDTH  stream data (FIFO head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks the final beat of the transfer.

Behaviour:
- Reset (async assert, sync-safe release):
  - State IDLE.
  - busy=0, done=0, bram_enb=0, bram_addrb=0, m_valid=0, m_last=0, m_data=0.
  - FIFO empty, in-flight=0, counters=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches base_addr into rd_addr and length into issue_cnt and beat_cnt. Go to RUN if length!=0, else go directly to DONE (no RAM reads issued).
  - RUN: issue reads; go to DRAIN once issue_cnt reaches 0.
  - DRAIN: wait for in-flight=0 and FIFO empty; then go to DONE.
  - DONE: done=1 for exactly one cycle; then IDLE.
- busy=1 in RUN, DRAIN and DONE; 0 in IDLE.
- start is ignored outside IDLE.
- Read issue in RUN, each cycle:
  - Condition: issue_cnt>0 and (fifo_count + in_flight - pop) < 2, where pop = m_valid & m_ready.
  - If issuing, the next cycle has bram_enb=1 and bram_addrb=rd_addr.
  - rd_addr increments modulo RAM_DEPTH (wraps to 0 past RAM_DEPTH-1); issue_cnt decrements.
  - If not issuing, bram_enb=0 and bram_addrb holds its value.
- Capture: each cycle with bram_enb=1 sets in_flight=1. On the next rising edge, bram_doutb is pushed into the FIFO. The credit rule guarantees the FIFO never overflows.
- Latency: start sampled at edge k → bram_enb=1 after edge k+1 → m_valid=1 after edge k+2.
- Throughput: with m_ready held at 1, one beat per cycle is sustained.
- Stream rules:
  - m_data, m_valid and m_last hold stable while m_valid=1 and m_ready=0.
  - A beat transfers on a rising edge with m_valid & m_ready; each transfer decrements beat_cnt.
  - m_last=1 exactly when the FIFO head is the beat with beat_cnt==1.
- Simultaneous push and pop on the same edge is legal; fifo_count stays unchanged.
- Length equal to RAM_DEPTH reads every entry once, wrapping if base_addr != 0.
- Reset mid-transfer:
  - Aborts immediately: FIFO is discarded, bram_enb=0, no done pulse.
  - Any RAM read data returning after reset is ignored.

Test Plan:
- Basic: RAM[i]=i for all i; start with base=0x10, len=4, m_ready=1 → bram_enb high for 4 consecutive cycles with addr 0x10..0x13; beats 0x10..0x13 on consecutive cycles; first m_valid 2 cycles after start; m_last on 0x13; done 1 cycle after the last beat; busy falls with done.
- Back-pressure: len=8, m_ready toggled 1,0,0,1,... → all 8 beats delivered in order with no loss or duplication; m_data stable while stalled; (fifo_count + in_flight) never exceeds 2; bram_enb stops while stalled.
- Wrap: base=0xFE, len=4 → addresses 0xFE, 0xFF, 0x00, 0x01; data matches.
- Zero length: start with len=0 → no bram_enb; done pulses on the cycle after start; m_valid stays 0.
- Start while busy: a second start during RUN → ignored; the first transfer completes unchanged; exactly one done pulse.
- Reset mid-transfer: len=16, reset_n low after 5 beats → all outputs go to reset values asynchronously; no done pulse. A new transfer base=0, len=2 then completes correctly.

Source files
------------

// File: rtl/bram_read_streamer.sv
// Read-side streamer for the buffer RAM: issues credit-limited reads and
// forwards the returning entries through a 2-entry FIFO onto a valid/ready stream.
module bram_read_streamer #(
    parameter int RAM_WIDTH = 128,
    parameter int RAM_DEPTH = 256,
    parameter int ADDR_W    = $clog2(RAM_DEPTH),
    parameter int LEN_W     = ADDR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     length,
    output logic                 busy,
    output logic                 done,
    output logic                 bram_enb,
    output logic [ADDR_W-1:0]    bram_addrb,
    input  logic [RAM_WIDTH-1:0] bram_doutb,
    output logic [RAM_WIDTH-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]    rd_addr;
    logic [LEN_W-1:0]     issue_cnt;
    logic [LEN_W-1:0]     beat_cnt;
    logic [RAM_WIDTH-1:0] fifo_mem [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           fifo_count;

    logic       push;
    logic       pop;
    logic       issue;
    logic       drained;
    logic [2:0] occ;

    // bram_enb doubles as the in-flight flag: its data lands on the next edge.
    assign push    = bram_enb;
    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_mem[rd_ptr];
    assign m_last  = m_valid && (beat_cnt == LEN_W'(1));
    assign pop     = m_valid && m_ready;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    assign occ     = {1'b0, fifo_count} + {2'b00, bram_enb} - {2'b00, pop};
    assign issue   = (state == RUN) && (issue_cnt != '0) && (occ < 3'd2);
    // Looks at post-edge occupancy so done follows the final beat by one cycle.
    assign drained = !bram_enb && ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (length == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue && (issue_cnt == LEN_W'(1))) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr    <= '0;
            issue_cnt  <= '0;
            beat_cnt   <= '0;
            bram_enb   <= 1'b0;
            bram_addrb <= '0;
        end else begin
            bram_enb <= issue;
            if ((state == IDLE) && start) begin
                rd_addr   <= base_addr;
                issue_cnt <= length;
                beat_cnt  <= length;
            end else begin
                if (issue) begin
                    bram_addrb <= rd_addr;
                    rd_addr    <= (rd_addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : rd_addr + 1'b1;
                    issue_cnt  <= issue_cnt - 1'b1;
                end
                if (pop) begin
                    beat_cnt <= beat_cnt - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= bram_doutb;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_read_streamer.sv
// Directed bench for bram_read_streamer: a combinational RAM model answers
// reads, a negedge monitor records issues/beats, and each task checks a scenario.
module tb_bram_read_streamer;

    localparam int RAM_WIDTH = 128;
    localparam int RAM_DEPTH = 256;
    localparam int ADDR_W    = 8;
    localparam int LEN_W     = 9;

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic [LEN_W-1:0]     length;
    logic                 busy;
    logic                 done;
    logic                 bram_enb;
    logic [ADDR_W-1:0]    bram_addrb;
    logic [RAM_WIDTH-1:0] bram_doutb;
    logic [RAM_WIDTH-1:0] m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic                 m_last;

    int checks;
    int failures;

    bram_read_streamer #(
        .RAM_WIDTH(RAM_WIDTH),
        .RAM_DEPTH(RAM_DEPTH),
        .ADDR_W   (ADDR_W),
        .LEN_W    (LEN_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bram_enb  (bram_enb),
        .bram_addrb(bram_addrb),
        .bram_doutb(bram_doutb),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RAM_WIDTH-1:0] word_at(input logic [7:0] a);
        return {a, 8'h5A, 104'h0, a};
    endfunction

    // Entry contents are a function of the address; data is valid in the enb cycle.
    assign bram_doutb = bram_enb ? word_at(bram_addrb) : '0;

    int             ncyc;
    logic [7:0]     addr_q[$];
    logic [127:0]   data_q[$];
    logic           last_q[$];
    int             done_cnt, enb_total, pop_total, max_occ, stall_err;
    int             start_n, enb_n, valid_n, lastbeat_n, done_n;
    logic           prev_stall;
    logic [127:0]   prev_data;

    task automatic clear_mon();
        addr_q.delete();
        data_q.delete();
        last_q.delete();
        done_cnt   = 0;
        enb_total  = 0;
        pop_total  = 0;
        max_occ    = 0;
        stall_err  = 0;
        start_n    = -1;
        enb_n      = -1;
        valid_n    = -1;
        lastbeat_n = -1;
        done_n     = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
    endtask

    initial begin
        ncyc = 0;
        forever begin
            @(negedge clk);
            ncyc = ncyc + 1;
            if (reset_n) begin
                if (start && start_n < 0) start_n = ncyc;
                if (bram_enb) begin
                    addr_q.push_back(bram_addrb);
                    enb_total = enb_total + 1;
                    if (enb_n < 0) enb_n = ncyc;
                end
                if (enb_total - pop_total > max_occ) max_occ = enb_total - pop_total;
                if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err = stall_err + 1;
                if (m_valid && valid_n < 0) valid_n = ncyc;
                if (m_valid && m_ready) begin
                    data_q.push_back(m_data);
                    last_q.push_back(m_last);
                    pop_total = pop_total + 1;
                    if (m_last) lastbeat_n = ncyc;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                if (done) begin
                    done_cnt = done_cnt + 1;
                    done_n   = ncyc;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] b, input logic [8:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        clear_mon();
        #3;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (bram_enb !== 1'b0) begin failures++; $display("FAIL reset_enb got=%b exp=0", bram_enb); end
        checks++; if (bram_addrb !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", bram_addrb); end
        checks++; if (m_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
        checks++; if (m_last !== 1'b0)   begin failures++; $display("FAIL reset_last got=%b exp=0", m_last); end
        checks++; if (m_data !== '0)     begin failures++; $display("FAIL reset_data got=%h exp=0", m_data); end
        cyc(); cyc();
        #3 reset_n = 1'b1;
        cyc(); cyc();
    endtask

    task automatic test_basic();
        bit ok;
        clear_mon();
        m_ready = 1'b1;
        pulse_start(8'h10, 9'd4);
        wait_done(30, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL basic_timeout got=%b exp=1", ok); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=1", busy); end
        cyc();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL basic_idle_after got=%b%b exp=00", busy, done); end
        checks++; if (addr_q.size() != 4) begin failures++; $display("FAIL basic_enb_count got=%0d exp=4", addr_q.size()); end
        checks++; if (data_q.size() != 4) begin failures++; $display("FAIL basic_beat_count got=%0d exp=4", data_q.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a;
            a = 8'h10 + 8'(i);
            if (i < addr_q.size()) begin
                checks++; if (addr_q[i] !== a) begin failures++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, addr_q[i], a); end
            end
            if (i < data_q.size()) begin
                checks++; if (data_q[i] !== word_at(a)) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, data_q[i], word_at(a)); end
                checks++; if (last_q[i] !== (i == 3)) begin failures++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, last_q[i], (i == 3)); end
            end
        end
        checks++; if (enb_n != start_n + 2) begin failures++; $display("FAIL basic_enb_latency got=%0d exp=%0d", enb_n, start_n + 2); end
        checks++; if (valid_n != start_n + 3) begin failures++; $display("FAIL basic_valid_latency got=%0d exp=%0d", valid_n, start_n + 3); end
        checks++; if (lastbeat_n != start_n + 6) begin failures++; $display("FAIL basic_last_time got=%0d exp=%0d", lastbeat_n, start_n + 6); end
        checks++; if (done_n != start_n + 7) begin failures++; $display("FAIL basic_done_time got=%0d exp=%0d", done_n, start_n + 7); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_backpressure();
        int k;
        logic pat [4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        clear_mon();
        m_ready = pat[0];
        pulse_start(8'h30, 9'd8);
        k = 1;
        while (done_cnt == 0 && k < 100) begin
            m_ready = pat[k % 4];
            cyc();
            k++;
        end
        m_ready = 1'b1;
        cyc();
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
        checks++; if (data_q.size() != 8) begin failures++; $display("FAIL bp_beat_count got=%0d exp=8", data_q.size()); end
        checks++; if (addr_q.size() != 8) begin failures++; $display("FAIL bp_enb_count got=%0d exp=8", addr_q.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            a = 8'h30 + 8'(i);
            if (i < data_q.size()) begin
                checks++; if (data_q[i] !== word_at(a)) begin failures++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, data_q[i], word_at(a)); end
                checks++; if (last_q[i] !== (i == 7)) begin failures++; $display("FAIL bp_last[%0d] got=%b exp=%b", i, last_q[i], (i == 7)); end
            end
        end
        checks++; if (max_occ > 2) begin failures++; $display("FAIL bp_occupancy got=%0d exp<=2", max_occ); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err); end
    endtask

    task automatic test_wrap();
        bit ok;
        logic [7:0] exp_a [4];
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        clear_mon();
        m_ready = 1'b1;
        pulse_start(8'hFE, 9'd4);
        wait_done(30, ok);
        cyc();
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL wrap_timeout got=%b exp=1", ok); end
        checks++; if (addr_q.size() != 4 || data_q.size() != 4) begin failures++; $display("FAIL wrap_counts got=%0d/%0d exp=4/4", addr_q.size(), data_q.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < addr_q.size()) begin
                checks++; if (addr_q[i] !== exp_a[i]) begin failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, addr_q[i], exp_a[i]); end
            end
            if (i < data_q.size()) begin
                checks++; if (data_q[i] !== word_at(exp_a[i])) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, data_q[i], word_at(exp_a[i])); end
            end
        end
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_mon();
        m_ready = 1'b1;
        pulse_start(8'h33, 9'd0);
        wait_done(10, ok);
        cyc(); cyc();
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL zero_timeout got=%b exp=1", ok); end
        checks++; if (done_n != start_n + 1) begin failures++; $display("FAIL zero_done_time got=%0d exp=%0d", done_n, start_n + 1); end
        checks++; if (addr_q.size() != 0) begin failures++; $display("FAIL zero_enb_count got=%0d exp=0", addr_q.size()); end
        checks++; if (valid_n != -1) begin failures++; $display("FAIL zero_valid_seen got=%0d exp=-1", valid_n); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_start_busy();
        int k;
        clear_mon();
        m_ready = 1'b1;
        pulse_start(8'h20, 9'd6);
        cyc();
        pulse_start(8'h80, 9'd2);
        k = 0;
        while (done_cnt == 0 && k < 40) begin
            cyc();
            k++;
        end
        for (int i = 0; i < 6; i++) cyc();
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", done_cnt); end
        checks++; if (addr_q.size() != 6 || data_q.size() != 6) begin failures++; $display("FAIL busy_counts got=%0d/%0d exp=6/6", addr_q.size(), data_q.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] a;
            a = 8'h20 + 8'(i);
            if (i < addr_q.size()) begin
                checks++; if (addr_q[i] !== a) begin failures++; $display("FAIL busy_addr[%0d] got=%h exp=%h", i, addr_q[i], a); end
            end
            if (i < data_q.size()) begin
                checks++; if (data_q[i] !== word_at(a)) begin failures++; $display("FAIL busy_data[%0d] got=%h exp=%h", i, data_q[i], word_at(a)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k;
        clear_mon();
        m_ready = 1'b1;
        pulse_start(8'h40, 9'd16);
        k = 0;
        while (data_q.size() < 5 && k < 40) begin
            cyc();
            k++;
        end
        checks++; if (data_q.size() != 5) begin failures++; $display("FAIL rst_beats_before got=%0d exp=5", data_q.size()); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
        checks++; if (bram_enb !== 1'b0 || bram_addrb !== 8'h00) begin failures++; $display("FAIL rst_ram_port got=%b/%h exp=0/00", bram_enb, bram_addrb); end
        checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin failures++; $display("FAIL rst_stream_ctl got=%b%b exp=00", m_valid, m_last); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL rst_stream_data got=%h exp=0", m_data); end
        cyc(); cyc();
        #3 reset_n = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_quiet_after got=%b%b exp=00", m_valid, busy); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", done_cnt); end
        checks++; if (data_q.size() != 5) begin failures++; $display("FAIL rst_no_extra_beats got=%0d exp=5", data_q.size()); end
        clear_mon();
        pulse_start(8'h00, 9'd2);
        wait_done(20, ok);
        cyc();
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rst_retry_timeout got=%b exp=1", ok); end
        checks++; if (data_q.size() != 2) begin failures++; $display("FAIL rst_retry_count got=%0d exp=2", data_q.size()); end
        for (int i = 0; i < 2; i++) begin
            if (i < data_q.size()) begin
                checks++; if (data_q[i] !== word_at(8'(i))) begin failures++; $display("FAIL rst_retry_data[%0d] got=%h exp=%h", i, data_q[i], word_at(8'(i))); end
                checks++; if (last_q[i] !== (i == 1)) begin failures++; $display("FAIL rst_retry_last[%0d] got=%b exp=%b", i, last_q[i], (i == 1)); end
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL rst_retry_done got=%0d exp=1", done_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_len();
        test_start_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
